// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift controller: FSM state encoding
// and default sizing constants.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV_W = 8;

endpackage

// File: rtl/serial_shift_ctrl_dff_cell.sv
// One-bit D register used as a single stage of the serial shift chain.
// Asynchronous active-low reset clears the stage to 0.
module dff_cell (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= d;
  end

endmodule

// File: rtl/serial_shift_ctrl.sv
// Parallel-in/serial-out controller: accepts a word on a valid/ready handshake
// and shifts it out LSB-first through a chain of dff_cell stages.
module serial_shift_ctrl
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int            BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state, next_state;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] tick_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-1:0] chain_q;
  logic [WIDTH-1:0] chain_d;
  logic [WIDTH-1:0] shifted;
  logic             load, shift, clear, tick_end, last_bit;

  assign tick_end = (tick_cnt == div_q);
  assign last_bit = (bit_cnt == LAST_BIT);
  assign load     = (state == IDLE) && in_valid;
  assign shift    = (state == SHIFT) && tick_end && !last_bit;
  assign clear    = (state == DONE);
  assign shifted  = {1'b0, chain_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    frame      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = SHIFT;
      end
      SHIFT: begin
        busy       = 1'b1;
        sout       = chain_q[0];
        sout_valid = 1'b1;
        frame      = (bit_cnt == '0);
        if (tick_end && last_bit) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Counters saturate at their terminal values; div is captured only on the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            div_q    <= div;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (tick_end) begin
            tick_cnt <= '0;
            if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          tick_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  // Per-stage mux: load, shift toward stage 0, clear, or hold.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    assign chain_d[i] = load  ? in_data[i] :
                        shift ? shifted[i] :
                        clear ? 1'b0       :
                                chain_q[i];

    dff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .d   (chain_d[i]),
      .q   (chain_q[i])
    );
  end

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Directed self-checking bench for serial_shift_ctrl (WIDTH=8, DIV_W=8).
// Expected serial streams are derived from the words the bench itself drives.
module tb_serial_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] div = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       sout;
  logic       sout_valid;
  logic       frame;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  serial_shift_ctrl #(.WIDTH(8), .DIV_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .div        (div),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .sout       (sout),
    .sout_valid (sout_valid),
    .frame      (frame),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] data, input logic [7:0] d);
    in_valid = v;
    in_data  = data;
    div      = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " in_ready"},   32'(in_ready),   32'd1);
    checkOutput({tag, " busy"},       32'(busy),       32'd0);
    checkOutput({tag, " sout"},       32'(sout),       32'd0);
    checkOutput({tag, " sout_valid"}, 32'(sout_valid), 32'd0);
    checkOutput({tag, " frame"},      32'(frame),      32'd0);
    checkOutput({tag, " done"},       32'(done),       32'd0);
  endtask

  // Steps through the handshake edge, every bit cycle, the done cycle and
  // the following idle cycle. When issue is 0 the caller already holds in_valid.
  task automatic runWord(input string tag, input logic [7:0] data, input logic [7:0] dv,
                         input bit issue, input logic nv, input logic [7:0] nd,
                         input logic [7:0] ndiv);
    int per;
    per = int'(dv) + 1;
    if (issue) applyStimulus(1'b1, data, dv);
    step();
    applyStimulus(nv, nd, ndiv);
    for (int i = 0; i < 8 * per; i++) begin
      checkOutput($sformatf("%s sout c%0d", tag, i),  32'(sout),       32'(data[i / per]));
      checkOutput($sformatf("%s valid c%0d", tag, i), 32'(sout_valid), 32'd1);
      checkOutput($sformatf("%s frame c%0d", tag, i), 32'(frame),      32'(i < per));
      checkOutput($sformatf("%s busy c%0d", tag, i),  32'(busy),       32'd1);
      checkOutput($sformatf("%s done c%0d", tag, i),  32'(done),       32'd0);
      checkOutput($sformatf("%s rdy c%0d", tag, i),   32'(in_ready),   32'd0);
      step();
    end
    checkOutput({tag, " done pulse"},  32'(done),       32'd1);
    checkOutput({tag, " done sout"},   32'(sout),       32'd0);
    checkOutput({tag, " done valid"},  32'(sout_valid), 32'd0);
    checkOutput({tag, " done busy"},   32'(busy),       32'd1);
    checkOutput({tag, " done rdy"},    32'(in_ready),   32'd0);
    step();
    checkIdle({tag, " after"});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");

    applyStimulus(1'b1, 8'hA5, 8'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      checkIdle($sformatf("reset c%0d", c));
    end
    applyStimulus(1'b0, 8'h00, 8'd0);
    rst = 1'b1;
    step();
    checkIdle("reset release");

    runWord("a5", 8'hA5, 8'd0, 1'b1, 1'b0, 8'h00, 8'd0);
    runWord("01", 8'h01, 8'd2, 1'b1, 1'b0, 8'h00, 8'd2);

    // Second word is presented during the first; its handshake lands on the idle cycle.
    runWord("ff", 8'hFF, 8'd0, 1'b1, 1'b1, 8'h00, 8'd0);
    runWord("00", 8'h00, 8'd0, 1'b0, 1'b0, 8'h00, 8'd0);

    applyStimulus(1'b1, 8'h3C, 8'd0);
    step();
    applyStimulus(1'b0, 8'h00, 8'd0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("3c sout c%0d", i), 32'(sout), 32'(((8'h3C) >> i) & 8'h01));
      step();
    end
    checkOutput("3c bit4 sout",  32'(sout),       32'd1);
    checkOutput("3c bit4 valid", 32'(sout_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    checkIdle("midreset async");
    step();
    checkIdle("midreset held");
    #2;
    rst = 1'b1;
    step();
    checkIdle("midreset released");
    step();
    checkIdle("midreset no resume");

    runWord("81", 8'h81, 8'd0, 1'b1, 1'b0, 8'h00, 8'd0);

    runWord("5a div", 8'h5A, 8'd1, 1'b1, 1'b0, 8'h00, 8'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_shift_ctrl.md
# serial_shift_ctrl

Controller that sequences a WIDTH-stage chain of one-bit D flip-flop cells as a parallel-in/serial-out shifter. It accepts a word over a valid/ready handshake, loads it into the chain, and shifts it out LSB-first with a programmable bit period. It also generates frame, valid and done strobes for the downstream serial consumer. It sits between a word producer and any single-wire serial sink in the design.

## Interface
Parameters:
- WIDTH, 8, bits per word and number of flip-flop stages (≥2)
- DIV_W, 8, width of the bit-period divisor

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- div  in  DIV_W  bit period minus 1 in clk cycles; sampled only at handshake
- in_valid  in  1  producer has a word on in_data
- in_ready  out  1  controller can accept a word (state IDLE)
- in_data  in  WIDTH  word to serialize; only sampled at handshake
- sout  out  1  serial data, equals stage 0 of the chain while shifting, else 0
- sout_valid  out  1  high while sout carries a data bit
- frame  out  1  high during the first bit period of a word
- busy  out  1  high in SHIFT or DONE
- done  out  1  one-cycle pulse after the last bit period

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1:
  - load in_data into the chain;
  - latch div into div_q;
  - bit_cnt=0, tick_cnt=0;
  - go to SHIFT.
- SHIFT: sout=chain[0], sout_valid=1, frame=(bit_cnt==0).
  - tick_cnt increments each cycle until it equals div_q.
  - On the tick_cnt==div_q cycle with bit_cnt<WIDTH-1: chain shifts toward stage 0 (stage i takes stage i+1, top stage takes 0), bit_cnt+1, tick_cnt=0.
  - On the tick_cnt==div_q cycle with bit_cnt==WIDTH-1: go to DONE.
- DONE: done=1, sout=0, sout_valid=0, in_ready=0, chain cleared to 0. Unconditionally return to IDLE.
- Chain contents hold whenever not loading, shifting or clearing.
- in_valid while busy is ignored. No capture occurs and the producer must hold the word.
- Changes to div after the handshake have no effect until the next word.
- Counters: tick_cnt is DIV_W bits; bit_cnt is clog2(WIDTH) bits. Neither counter wraps past its terminal value.

## Timing
- Reset (rst low, any time, including mid-word):
  - state=IDLE, chain=0, counters=0;
  - sout=0, sout_valid=0, frame=0, busy=0, done=0;
  - in_ready=1, but no handshake is taken while rst is low.
  - A word in progress is abandoned and is not resumed.
- Handshake edge E0: bit 0 appears on sout in the cycle after E0.
- Each bit is held for exactly div_q+1 cycles. Bit k starts k·(div_q+1) cycles after E0's following cycle.
- div=0: one bit per cycle, so WIDTH consecutive cycles of sout_valid.
- done pulses in the cycle immediately after the last bit's final cycle.
- in_ready rises the cycle after done.
- Minimum word-to-word spacing (back-to-back in_valid) is WIDTH·(div+1)+2 cycles.
- frame is high for exactly div_q+1 cycles per word.
- sout_valid is high for exactly WIDTH·(div_q+1) cycles per word.

## Structure
- Package serial_pkg holds:
  - state encoding IDLE=2'b00, SHIFT=2'b01, DONE=2'b10;
  - default WIDTH and DIV_W constants.
- Sub-module dff_cell: one-bit D register with async active-low reset, reset value 0. It is instantiated WIDTH times via generate.
- The controller drives each cell's d through a per-stage mux: load in_data[i], shift from stage i+1, clear 0, or hold own q.
- FSM, counters and output decode live in serial_shift_ctrl.

## Test plan
- Reset: hold rst low 3 cycles with in_valid=1 → no capture; all outputs at reset values. Release → in_ready=1.
- Single word in_data=8'hA5, div=0 → sout=1,0,1,0,0,1,0,1 on 8 consecutive cycles after E0; frame only on the first; done in cycle 9; in_ready in cycle 10.
- in_data=8'h01, div=2 → sout high 3 cycles then low 21 cycles; sout_valid high 24 cycles; done once.
- Back-to-back: in_valid held high with 8'hFF then 8'h00, div=0 → second handshake exactly 10 cycles after the first; first word is not corrupted.
- Mid-word reset: assert rst during bit 4 of 8'h3C → outputs clear within the same cycle; after release, a new word 8'h81 serializes correctly.
- div change: div=1 at handshake, div=5 driven during SHIFT → every bit is still held 2 cycles.
